multi_cycle_control_fsm: RTL

Multi-cycle RV32I control sequencer. It drives the shared datapath (single ALU, single unified memory port, register file, PC, IR/MDR/ALUOut latches) through IF/ID/EX/MEM/WB steps, one instruction at a time. It sits beside the datapath, takes the opcode from the IR and status flags, and emits per-cycle enables and mux selects. Memory accesses use a req/ready handshake so variable-latency memory is tolerated.

---
 rtl/multi_cycle_control_fsm.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_control_fsm.sv
// Control sequencer for a multi-cycle RV32I datapath: walks IF/ID/EX/MEM/WB
// per instruction and emits per-cycle enables and mux selects.
module multi_cycle_control_fsm #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [6:0]      opcode,
  input  logic            alu_bcond,
  input  logic            halt_cond,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_read,
  output logic            mem_write,
  output logic            i_or_d,
  output logic            ir_write,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            pc_to_reg,
  output logic            alu_src_a,
  output logic            alu_src_b,
  output logic [1:0]      alu_op,
  output logic            pc_write,
  output logic            pc_sel,
  output logic            is_ecall,
  output logic            illegal_inst,
  output logic            halted,
  output logic            retire,
  output logic [XLEN-1:0] retired_count
);

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;

  localparam bit          WAIT_EN    = (MAX_WAIT > 0);
  localparam logic [31:0] WAIT_LIMIT = WAIT_EN ? 32'(MAX_WAIT - 1) : 32'd0;

  state_t            state_q, state_d;
  logic [31:0]       wait_q, wait_d;
  logic [XLEN-1:0]   retired_count_q;
  logic              wait_expired;

  assign wait_expired  = WAIT_EN && (wait_q == WAIT_LIMIT);
  assign retired_count = retired_count_q;

  // NOTE: every output and next-state value gets a default before the case,
  // so no path through this block can infer a latch.
  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    mem_req      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    i_or_d       = 1'b0;
    ir_write     = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    pc_to_reg    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    pc_write     = 1'b0;
    pc_sel       = 1'b0;
    is_ecall     = 1'b0;
    illegal_inst = 1'b0;
    halted       = 1'b0;
    retire       = 1'b0;

    // Outputs are held low while reset is asserted so an in-flight request
    // is dropped immediately rather than at the next edge.
    if (!reset) begin
      unique case (state_q)
        S_IF: begin
          mem_req  = 1'b1;
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            state_d  = S_ID;
          end else if (wait_expired) begin
            illegal_inst = 1'b1;
            state_d      = S_HALT;
          end else begin
            wait_d = wait_q + 32'd1;
          end
        end
        S_ID: begin
          alu_src_b = 1'b1;
          unique case (opcode)
            OP_SYSTEM: begin
              is_ecall = 1'b1;
              if (halt_cond) begin
                state_d = S_HALT;
              end else begin
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = S_IF;
              end
            end
            OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR: state_d = S_EX;
            default: begin
              illegal_inst = 1'b1;
              pc_write     = 1'b1;
              state_d      = S_IF;
            end
          endcase
        end
        S_EX: begin
          state_d = S_WB;
          unique case (opcode)
            OP_ARITH: begin
              alu_src_a = 1'b1;
              alu_op    = ALU_FN;
            end
            OP_ARITH_IMM: begin
              alu_src_a = 1'b1;
              alu_src_b = 1'b1;
              alu_op    = ALU_FN;
            end
            OP_LOAD, OP_STORE: begin
              alu_src_a = 1'b1;
              alu_src_b = 1'b1;
              state_d   = S_MEM;
            end
            OP_BRANCH: begin
              alu_src_a = 1'b1;
              alu_op    = ALU_BR;
              pc_write  = 1'b1;
              pc_sel    = alu_bcond;
              retire    = 1'b1;
              state_d   = S_IF;
            end
            OP_JAL:  alu_src_b = 1'b1;
            OP_JALR: begin
              alu_src_a = 1'b1;
              alu_src_b = 1'b1;
            end
            default: state_d = S_IF;
          endcase
        end
        S_MEM: begin
          mem_req   = 1'b1;
          i_or_d    = 1'b1;
          mem_read  = (opcode == OP_LOAD);
          mem_write = (opcode == OP_STORE);
          if (mem_ready) begin
            if (opcode == OP_STORE) begin
              pc_write = 1'b1;
              retire   = 1'b1;
              state_d  = S_IF;
            end else begin
              state_d = S_WB;
            end
          end else if (wait_expired) begin
            illegal_inst = 1'b1;
            state_d      = S_HALT;
          end else begin
            wait_d = wait_q + 32'd1;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          pc_write  = 1'b1;
          state_d   = S_IF;
          if (opcode == OP_LOAD) begin
            mem_to_reg = 1'b1;
          end else if (opcode == OP_JAL || opcode == OP_JALR) begin
            pc_to_reg = 1'b1;
            pc_sel    = 1'b1;
          end
        end
        S_HALT: halted = 1'b1;
        default: state_d = S_IF;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IF;
      wait_q          <= '0;
      retired_count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (retire) retired_count_q <= retired_count_q + 1'b1;
    end
  end

endmodule
